// File: rtl/fp_pkg.sv
// Shared types and constants for the fp_add_seq single-precision add/sub sequencer.
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = 27;

    localparam logic [31:0]      QNAN    = 32'h7FC00000;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        PACK  = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } operand_t;

    // Right shift that ORs every bit shifted out into bit 0 (sticky).
    function automatic logic [SIG_W-1:0] shr_sticky(input logic [SIG_W-1:0] sig,
                                                    input logic [4:0]       sh);
        logic [SIG_W:0] mask;
        logic           lost;
        mask = ((SIG_W+1)'(1) << sh) - (SIG_W+1)'(1);
        lost = |({1'b0, sig} & mask);
        return (sig >> sh) | {{(SIG_W-1){1'b0}}, lost};
    endfunction

endpackage

// File: rtl/fp_unpack.sv
// Classifies one IEEE single operand and builds its 27-bit significand {1, mant, guard}.
module fp_unpack
    import fp_pkg::*;
#(
    parameter int GUARD_W = 3
)
(
    input  logic [30:0] mag,
    input  logic        sign,
    output operand_t    opnd
);

    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;

    always_comb begin
        exp  = mag[30:23];
        mant = mag[22:0];
        // Denormal inputs are flushed: any zero exponent counts as a signed zero.
        zero = (exp == '0);
        opnd.sign    = sign;
        opnd.exp     = exp;
        opnd.is_zero = zero;
        opnd.is_inf  = (exp == EXP_MAX) && (mant == '0);
        opnd.is_nan  = (exp == EXP_MAX) && (mant != '0);
        opnd.sig     = zero ? '0 : {1'b1, mant, {GUARD_W{1'b0}}};
    end

endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754 single add/subtract sequencer with START/busy/done handshake.
// Define FP_ADD_RNE_EN for round-to-nearest-even in PACK; default build truncates.
module fp_add_seq
    import fp_pkg::*;
#(
    parameter int GUARD_W   = 3,
    parameter int MAX_SHIFT = 24 + GUARD_W
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic [31:0] OP_A,
    input  logic [31:0] OP_B,
    input  logic        SUB,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        invalid,
    output logic [2:0]  state
);

    localparam logic [4:0] MAX_SH = 5'(MAX_SHIFT);

    // Handshake: START is sampled only in IDLE (busy=0); busy rises the cycle after
    // acceptance and falls when DONE exits; done pulses once with result/flags valid,
    // and result/flags hold until the next operation's PACK.
    state_t            state_q;
    logic [31:0]       a_q, b_q;
    logic              sub_q;
    logic [SIG_W-1:0]  sig_a, sig_b;
    logic              sign_a, sign_b, sign_r;
    logic signed [9:0] exp_q;
    logic [SIG_W:0]    sum_q;
    logic              special_q, spec_inv_q;
    logic [31:0]       spec_res_q;

    operand_t ua, ub;

    fp_unpack #(.GUARD_W(GUARD_W)) u_unpack_a (
        .mag  (a_q[30:0]),
        .sign (a_q[31]),
        .opnd (ua)
    );

    fp_unpack #(.GUARD_W(GUARD_W)) u_unpack_b (
        .mag  (b_q[30:0]),
        .sign (b_q[31] ^ sub_q),
        .opnd (ub)
    );

    assign state = state_q;

    logic             a_big;
    logic [7:0]       exp_diff;
    logic [4:0]       sh;
    logic [SIG_W-1:0] al_a, al_b;
    logic             special, spec_inv;
    logic [31:0]      spec_res;

    always_comb begin
        a_big    = (ua.exp >= ub.exp);
        exp_diff = a_big ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
        sh       = (exp_diff > {3'b000, MAX_SH}) ? MAX_SH : exp_diff[4:0];
        al_a     = a_big ? ua.sig : shr_sticky(ua.sig, sh);
        al_b     = a_big ? shr_sticky(ub.sig, sh) : ub.sig;

        special  = 1'b1;
        spec_inv = 1'b0;
        spec_res = '0;
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (ua.is_inf) begin
            spec_res = {ua.sign, EXP_MAX, {MANT_W{1'b0}}};
        end else if (ub.is_inf) begin
            spec_res = {ub.sign, EXP_MAX, {MANT_W{1'b0}}};
        end else if (ua.is_zero && ub.is_zero) begin
            spec_res = {ua.sign & ub.sign, 31'b0};
        end else if (ua.is_zero) begin
            spec_res = {ub.sign, b_q[30:0]};
        end else if (ub.is_zero) begin
            spec_res = a_q;
        end else begin
            special = 1'b0;
        end
    end

    logic              round_up;
    logic [24:0]       mant25;
    logic signed [9:0] exp_p;
    logic [31:0]       pack_res;
    logic              pack_ovf, pack_unf;

    always_comb begin
`ifdef FP_ADD_RNE_EN
        round_up = sum_q[GUARD_W-1] & (sum_q[GUARD_W-2] | (|sum_q[GUARD_W-3:0]) | sum_q[GUARD_W]);
`else
        round_up = 1'b0;
`endif
        mant25 = {1'b0, sum_q[SIG_W-1:GUARD_W]} + {24'b0, round_up};
        // A rounding carry leaves mant25 = 1.000..0, so only the exponent moves.
        exp_p  = exp_q + $signed({9'b0, mant25[24]});

        pack_ovf = 1'b0;
        pack_unf = 1'b0;
        if (special_q) begin
            pack_res = spec_res_q;
        end else if (sum_q == '0) begin
            pack_res = {sign_r, 31'b0};
        end else if ((exp_q <= 10'sd0) || !sum_q[SIG_W-1]) begin
            pack_res = {sign_r, 31'b0};
            pack_unf = 1'b1;
        end else if (exp_p >= 10'sd255) begin
            pack_res = {sign_r, EXP_MAX, {MANT_W{1'b0}}};
            pack_ovf = 1'b1;
        end else begin
            pack_res = {sign_r, exp_p[7:0], mant25[22:0]};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            invalid    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            sig_a      <= '0;
            sig_b      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            sign_r     <= 1'b0;
            exp_q      <= '0;
            sum_q      <= '0;
            special_q  <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (START) begin
                        a_q     <= OP_A;
                        b_q     <= OP_B;
                        sub_q   <= SUB;
                        busy    <= 1'b1;
                        state_q <= ALIGN;
                    end
                end
                ALIGN: begin
                    sig_a      <= al_a;
                    sig_b      <= al_b;
                    sign_a     <= ua.sign;
                    sign_b     <= ub.sign;
                    exp_q      <= $signed({2'b00, a_big ? ua.exp : ub.exp});
                    special_q  <= special;
                    spec_inv_q <= spec_inv;
                    spec_res_q <= spec_res;
                    state_q    <= ADD;
                end
                ADD: begin
                    // Aligned significands share one exponent, so comparing them compares magnitudes.
                    if (sign_a == sign_b) begin
                        sum_q  <= {1'b0, sig_a} + {1'b0, sig_b};
                        sign_r <= sign_a;
                    end else if (sig_a >= sig_b) begin
                        sum_q  <= {1'b0, sig_a - sig_b};
                        sign_r <= (sig_a == sig_b) ? 1'b0 : sign_a;
                    end else begin
                        sum_q  <= {1'b0, sig_b - sig_a};
                        sign_r <= sign_b;
                    end
                    state_q <= NORM;
                end
                NORM: begin
                    if (special_q) begin
                        state_q <= PACK;
                    end else if (sum_q[SIG_W]) begin
                        sum_q   <= {1'b0, sum_q[SIG_W:2], sum_q[1] | sum_q[0]};
                        exp_q   <= exp_q + 10'sd1;
                        state_q <= PACK;
                    end else if (!sum_q[SIG_W-1] && (sum_q != '0) && (exp_q > 10'sd1)) begin
                        sum_q <= sum_q << 1;
                        exp_q <= exp_q - 10'sd1;
                    end else begin
                        state_q <= PACK;
                    end
                end
                PACK: begin
                    result    <= pack_res;
                    overflow  <= pack_ovf;
                    underflow <= pack_unf;
                    invalid   <= special_q & spec_inv_q;
                    done      <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: hand-computed results, flags, latency and handshake checks.
module tb_fp_add_seq;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [31:0] OP_A;
    logic [31:0] OP_B;
    logic        SUB;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        invalid;
    logic [2:0]  dbg_state;

    int tests;
    int fails;
    logic [31:0] exp_q[$];

    fp_add_seq dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .SUB       (SUB),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid),
        .state     (dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    // Runs one operation; eflags = {overflow, underflow, invalid}.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] er, input logic [2:0] eflags,
                          input int elat);
        int n;
        logic busy_ok;
        logic [31:0] er_pop;
        wait_idle();
        @(negedge CLK);
        OP_A = a; OP_B = b; SUB = s; START = 1'b1;
        exp_q.push_back(er);
        @(posedge CLK); #1;
        START = 1'b0;
        busy_ok = busy;
        n = 0;
        while (!done && n < 100) begin
            @(posedge CLK); #1;
            n++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        er_pop = exp_q.pop_front();
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " latency"}, n, elat);
        check({tag, " result"}, result, er_pop);
        check({tag, " flags"}, {29'b0, overflow, underflow, invalid}, {29'b0, eflags});
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        @(posedge CLK); #1;
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
        check({tag, " held"}, result, er_pop);
    endtask

    initial begin
        int n;
        logic [31:0] exp_rne;
        tests = 0;
        fails = 0;
        RST_N = 1'b0;
        START = 1'b0;
        OP_A  = '0;
        OP_B  = '0;
        SUB   = 1'b0;

        // Reset state
        @(posedge CLK); #1;
        check("rst busy",  {31'b0, busy}, 32'd0);
        check("rst done",  {31'b0, done}, 32'd0);
        check("rst result", result, 32'h0);
        check("rst flags", {29'b0, overflow, underflow, invalid}, 32'd0);
        check("rst state", {29'b0, dbg_state}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        // Main function
        run_op("1p1",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
        run_op("k24",     32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 3'b000, 28);
        run_op("ovf",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100, 4);
        run_op("inf-inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b001, 4);
`ifdef FP_ADD_RNE_EN
        exp_rne = 32'h3F800001;
`else
        exp_rne = 32'h3F800000;
`endif
        run_op("round",   32'h3F800000, 32'h33C00000, 1'b0, exp_rne,      3'b000, 4);
        run_op("3m1",     32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 4);
        run_op("1m075",   32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 6);
        run_op("1m1",     32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 4);
        run_op("neg sub", 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 3'b000, 4);
        run_op("zero a",  32'h00000000, 32'h40490FDB, 1'b0, 32'h40490FDB, 3'b000, 4);
        run_op("neg0",    32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 4);
        run_op("nan",     32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001, 4);
        run_op("inf",     32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 4);
        run_op("unf",     32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b010, 4);

        // START while busy is ignored
        @(negedge CLK);
        OP_A = 32'h3F800000; OP_B = 32'h3F7FFFFF; SUB = 1'b1; START = 1'b1;
        exp_q.push_back(32'h33800000);
        @(posedge CLK); #1;
        START = 1'b0;
        n = 0;
        repeat (3) begin @(posedge CLK); #1; n++; end
        @(negedge CLK);
        OP_A = 32'h3F800000; OP_B = 32'h3F800000; SUB = 1'b0; START = 1'b1;
        @(posedge CLK); #1;
        n++;
        START = 1'b0;
        while (!done && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        check("ignore latency", n, 28);
        check("ignore result", result, exp_q.pop_front());
        // Next START lands in the cycle right after DONE
        run_op("after done", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);

        // Asynchronous reset in the middle of NORM
        @(negedge CLK);
        OP_A = 32'h3F800000; OP_B = 32'h3F7FFFFF; SUB = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(posedge CLK);
        #3;
        check("mid norm state", {29'b0, dbg_state}, 32'd3);
        RST_N = 1'b0;
        #1;
        check("arst busy",   {31'b0, busy}, 32'd0);
        check("arst done",   {31'b0, done}, 32'd0);
        check("arst result", result, 32'h0);
        check("arst flags",  {29'b0, overflow, underflow, invalid}, 32'd0);
        n = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            if (done) n++;
        end
        check("arst no done", n, 0);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;
        run_op("post rst", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
